// File: rtl/fixed_point_dot_product_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_point_dot_product_ctrl_if
//  Brief    : Operand-load and start/done bus between the host and the
//             dot-product sequencer.
//  Revision : 1.0
// ============================================================================
interface fixed_point_dot_product_ctrl_if #(
    parameter int WORD_LENGTH = 6,
    parameter int DEPTH       = 8
);
    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_len_w  = $clog2(DEPTH + 1);

    logic                          wr_en;
    logic [c_addr_w-1:0]           wr_addr;
    logic signed [WORD_LENGTH-1:0] wr_a;
    logic signed [WORD_LENGTH-1:0] wr_b;
    logic [c_len_w-1:0]            len;
    logic                          start;
    logic                          busy;
    logic                          done;
    logic signed [WORD_LENGTH-1:0] result;

    modport master (
        output wr_en, wr_addr, wr_a, wr_b, len, start,
        input  busy, done, result
    );

    modport slave (
        input  wr_en, wr_addr, wr_a, wr_b, len, start,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/fixed_point_dot_product_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_point_dot_product_ctrl
//  Brief    : Time-shared fixed-point MAC sequencer computing a dot product of
//             up to DEPTH operand pairs. Define MAC_SATURATE_EN to saturate
//             the accumulate add instead of wrapping.
//  Revision : 1.0
// ============================================================================
module fixed_point_dot_product_ctrl #(
    parameter int WORD_LENGTH  = 6,
    parameter int INTEGER_PART = 3,
    parameter int DEPTH        = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    fixed_point_dot_product_ctrl_if.slave bus
);
    localparam int FRACTIONAL_PART = WORD_LENGTH - INTEGER_PART;
    localparam int c_addr_w        = $clog2(DEPTH);
    localparam int c_len_w         = $clog2(DEPTH + 1);
    localparam int c_prod_w        = 2 * WORD_LENGTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        r_state;
    logic signed [WORD_LENGTH-1:0] r_buf_a [DEPTH];
    logic signed [WORD_LENGTH-1:0] r_buf_b [DEPTH];
    logic signed [WORD_LENGTH-1:0] r_acc;
    logic signed [WORD_LENGTH-1:0] r_result;
    logic [c_len_w-1:0]            r_idx;
    logic [c_len_w-1:0]            r_len;
    logic                          r_busy;
    logic                          r_done;

    logic [c_len_w-1:0]            w_len_clamped;
    logic [c_addr_w-1:0]           w_rd_addr;
    logic signed [c_prod_w-1:0]    w_prod;
    logic signed [WORD_LENGTH-1:0] w_slice;
    logic signed [WORD_LENGTH-1:0] w_acc_next;
    logic                          w_wr_fire;
    logic                          w_unused_prod_bits;

    assign w_len_clamped = (bus.len > c_len_w'(DEPTH)) ? c_len_w'(DEPTH) : bus.len;
    assign w_rd_addr     = r_idx[c_addr_w-1:0];
    assign w_wr_fire     = bus.wr_en && (r_state == IDLE);

    // Keep the middle Word_Length bits of the full product: truncation toward
    // -inf on the fractional side, integer overflow bits discarded.
    assign w_prod  = r_buf_a[w_rd_addr] * r_buf_b[w_rd_addr];
    assign w_slice = w_prod[c_prod_w-1-INTEGER_PART -: WORD_LENGTH];
    assign w_unused_prod_bits = ^{w_prod[c_prod_w-1 -: INTEGER_PART],
                                  w_prod[FRACTIONAL_PART-1:0]};

`ifdef MAC_SATURATE_EN
    logic signed [WORD_LENGTH:0] w_sum_ext;

    assign w_sum_ext = {w_slice[WORD_LENGTH-1], w_slice} + {r_acc[WORD_LENGTH-1], r_acc};

    always_comb begin
        w_acc_next = w_sum_ext[WORD_LENGTH-1:0];
        if (w_sum_ext[WORD_LENGTH] != w_sum_ext[WORD_LENGTH-1]) begin
            w_acc_next = w_sum_ext[WORD_LENGTH] ? {1'b1, {(WORD_LENGTH-1){1'b0}}}
                                                : {1'b0, {(WORD_LENGTH-1){1'b1}}};
        end
    end
`else
    assign w_acc_next = w_slice + r_acc;
`endif

    // Writes land at the same edge a start is sampled, so a same-cycle
    // write is already visible when RUN reads the buffers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_a[i] <= '0;
                r_buf_b[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_buf_a[bus.wr_addr] <= bus.wr_a;
            r_buf_b[bus.wr_addr] <= bus.wr_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_len  <= w_len_clamped;
                        r_acc  <= '0;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        if (w_len_clamped == '0) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + c_len_w'(1);
                    // Result is captured from the final sum on DONE entry.
                    if (r_idx == r_len - c_len_w'(1)) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_result <= w_acc_next;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
`default_nettype wire
